// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared widths, arbiter state encoding and read-tag type for the
//           data-memory arbiter.
// Revision: 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_AW = 12;
    localparam int DMEM_DW = 32;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_ACC = 1'b1
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_ACC = 1'b1;

    typedef struct packed {
        logic owner;
        logic is_read;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : arb_sat_counter
// Brief   : Saturating up-counter with synchronous clear (clear has priority).
// Revision: 1.0  initial release
// ============================================================================
module arb_sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_V);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Shares the single RAM data port between the processor and the FFT
//           accelerator. Processor has default priority; a starvation guard and
//           burst lock give the accelerator bounded access.
//           Optional macro DMEM_ARB_PERF_EN adds conflict/stall perf counters.
// Revision: 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_wren,
    input  logic [DMEM_AW-1:0] cpu_addr,
    input  logic [DMEM_DW-1:0] cpu_data,
    output logic               cpu_stall,
    output logic [DMEM_DW-1:0] cpu_q,
    output logic               cpu_rvalid,
    input  logic               acc_req,
    input  logic               acc_lock,
    input  logic               acc_wren,
    input  logic [DMEM_AW-1:0] acc_addr,
    input  logic [DMEM_DW-1:0] acc_data,
    output logic               acc_gnt,
    output logic [DMEM_DW-1:0] acc_q,
    output logic               acc_rvalid,
    output logic               ram_wEn,
    output logic [DMEM_AW-1:0] ram_addr,
    output logic [DMEM_DW-1:0] ram_dataIn,
    input  logic [DMEM_DW-1:0] ram_dataOut
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_conflicts,
    output logic [31:0]        perf_cpu_stalls
`endif
);

    arb_state_e  r_state;
    arb_state_e  w_state_next;
    rd_tag_t     r_tag;

    logic        w_cpu_win;
    logic        w_acc_win;
    logic        w_burst_last;
    logic [7:0]  w_wait_cnt;
    logic        w_wait_full;
    logic [7:0]  w_burst_cnt;
    logic        w_burst_unused;
    logic [8:0]  w_burst_after;

    arb_sat_counter #(
        .WIDTH (8),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .i_inc    (acc_req),
        .i_clr    (w_acc_win || !acc_req),
        .o_count  (w_wait_cnt),
        .o_at_max (w_wait_full)
    );

    arb_sat_counter #(
        .WIDTH (8),
        .MAX   (BURST_MAX)
    ) u_burst_cnt (
        .clock    (clock),
        .reset    (reset),
        .i_inc    (w_acc_win),
        .i_clr    (w_state_next == ARB_CPU),
        .o_count  (w_burst_cnt),
        .o_at_max (w_burst_unused)
    );

    // Burst length including the grant being made this cycle; a fresh burst
    // starts at one because the entry grant is issued from ARB_CPU.
    assign w_burst_after = ((r_state == ARB_ACC) ? {1'b0, w_burst_cnt} : 9'd0) + 9'd1;
    assign w_burst_last  = (w_burst_after >= 9'(BURST_MAX));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_CPU;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cpu_win    = 1'b0;
        w_acc_win    = 1'b0;
        case (r_state)
            ARB_CPU: begin
                w_acc_win = acc_req && (!cpu_req || (w_wait_cnt == 8'(MAX_WAIT)));
                w_cpu_win = cpu_req && !w_acc_win;
                if (w_acc_win && acc_lock && !w_burst_last) begin
                    w_state_next = ARB_ACC;
                end
            end
            ARB_ACC: begin
                w_acc_win = acc_req;
                if (!acc_req || !acc_lock || w_burst_last) begin
                    w_state_next = ARB_CPU;
                end
            end
            default: begin
                w_state_next = ARB_CPU;
            end
        endcase
    end

    assign cpu_stall = cpu_req && !w_cpu_win;
    assign acc_gnt   = acc_req && w_acc_win;

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (w_cpu_win) begin
            ram_wEn    = cpu_wren;
            ram_addr   = cpu_addr;
            ram_dataIn = cpu_data;
        end else if (w_acc_win) begin
            ram_wEn    = acc_wren;
            ram_addr   = acc_addr;
            ram_dataIn = acc_data;
        end
    end

    // The RAM returns data one cycle after the access, so remember who asked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag <= '0;
        end else begin
            r_tag.owner   <= w_acc_win ? OWNER_ACC : OWNER_CPU;
            r_tag.is_read <= (w_cpu_win && !cpu_wren) || (w_acc_win && !acc_wren);
        end
    end

    assign cpu_rvalid = r_tag.is_read && (r_tag.owner == OWNER_CPU);
    assign acc_rvalid = r_tag.is_read && (r_tag.owner == OWNER_ACC);
    assign cpu_q      = cpu_rvalid ? ram_dataOut : '0;
    assign acc_q      = acc_rvalid ? ram_dataOut : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_conflicts;
    logic [31:0] r_perf_cpu_stalls;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_conflicts  <= '0;
            r_perf_cpu_stalls <= '0;
        end else begin
            if (cpu_req && acc_req) begin
                r_perf_conflicts <= r_perf_conflicts + 32'd1;
            end
            if (cpu_stall) begin
                r_perf_cpu_stalls <= r_perf_cpu_stalls + 32'd1;
            end
        end
    end

    assign perf_conflicts  = r_perf_conflicts;
    assign perf_cpu_stalls = r_perf_cpu_stalls;
`endif

endmodule
`default_nettype wire
